host_spi: RTL and testbench
===========================

HOST_SPI -- requirements
Module: host_spi

Interface
REQ-001 Parameter DW, default 24: transmit frame width in bits; frame = {cmd[1:0], addr, 1'b0 turnaround, data}.
REQ-002 Parameter RX, default 18: receive data width in bits; RX < DW.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 spi_start  input  1  one-cycle request to launch a frame.
REQ-006 spi_tx_data  input  DW  frame to send, MSB first; sampled only in the cycle spi_start is seen.
REQ-007 spi_complete  output  1  one-cycle pulse when a frame finishes.
REQ-008 spi_rx_data  output  RX  last RX bits sampled from MISO in the most recent frame.
REQ-009 spi_rx_valid  output  1  one-cycle pulse marking spi_rx_data as updated.
REQ-010 spi_sck  output  1  SPI clock, mode 0 (idle low).
REQ-011 spi_csn  output  1  active-low chip select.
REQ-012 spi_mosi  output  1  serial data to the device.
REQ-013 spi_miso  input  1  serial data from the device.

Function
REQ-014 States are IDLE, LOW, HIGH and END; all outputs are registered.
REQ-015 IDLE: csn=1, sck=0, mosi=0, complete=0, rx_valid=0.
REQ-016 IDLE with spi_start=1 at edge E0: latch spi_tx_data, csn<=0, mosi<=tx[DW-1], clear bit counter, go to LOW.
REQ-017 LOW lasts one cycle, then sck<=1 and the state goes to HIGH.
REQ-018 HIGH lasts one cycle, then:
- sck<=0;
- spi_miso is shifted into the RX shift register (LSB in, shift left);
- the bit counter increments;
- if bits remain, mosi<=next lower tx bit and the state goes to LOW, otherwise to END.
REQ-019 Bit k timing: sck high from edge E(2k+1) to E(2k+2), k=0..DW-1; mosi is stable across each full high phase.
REQ-020 END at edge E(2DW+1):
- csn<=1, mosi<=0;
- spi_complete<=1 and spi_rx_valid<=1 for exactly one cycle;
- spi_rx_data<=the RX most recently sampled bits (the last RX sck periods of the frame);
- return to IDLE.
REQ-021 csn is low for exactly 2*DW+1 cycles per frame; frames produce exactly DW sck rising edges.
REQ-022 spi_rx_valid and spi_complete pulse on every frame, write or read; the command bits are not decoded.
REQ-023 spi_start while not IDLE, including in the END cycle, is ignored and not queued.
REQ-024 A new frame may start at the first IDLE cycle after END, i.e. with spi_start seen at E(2DW+2).
REQ-025 spi_rx_data holds its value between frames.

Reset
REQ-026 While rst=1 the block enters IDLE with csn=1, sck=0, mosi=0, complete=0, rx_valid=0, spi_rx_data=0 and counters cleared.
REQ-027 rst asserted mid-frame aborts the frame with no complete or rx_valid pulse, and the next frame starts cleanly.

Verification
REQ-028 Write frame: DW=24, tx=24'h810101 (cmd 10, addr 0, data 18'h10101) -> MOSI shows 1000_0001_0000_0001_0000_0001 MSB first on 24 sck rising edges, csn low 49 cycles, then one complete pulse.
REQ-029 Loopback: tie miso to mosi and send tx=24'h810102 -> spi_rx_data=18'h10102 with rx_valid and complete pulsing together once.
REQ-030 Read frame: a device model returns 18'h0ABCD on MISO, driven after each sck fall, over the last 18 bits of tx={2'b01,3'd5,1'b0,18'b0} -> spi_rx_data=18'h0ABCD.
REQ-031 Start pulses at E3 and at E(2DW+1) during a frame -> ignored: one frame, one complete; a start at E(2DW+2) launches the next frame.
REQ-032 Reset mid-frame: assert rst at bit 10 -> csn=1 and sck=0 the next cycle, no complete pulse, spi_rx_data=0; the next frame is correct.
REQ-033 Back-to-back: eight writes to addr 0..7 with data 18'h10101..18'h10108 -> eight complete pulses and the correct MOSI stream for each.

Source files
------------

// File: rtl/host_spi.sv
// host_spi: SPI mode-0 master that shifts one DW-bit frame out on MOSI,
// MSB first, and captures the last RX bits of MISO. Each SCK bit takes two
// system clocks: one with SCK low, then one with SCK high. Every output
// comes straight from a flop.
module host_spi #(
  parameter int DW = 24,
  parameter int RX = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_start,
  input  logic [DW-1:0] spi_tx_data,
  output logic          spi_complete,
  output logic [RX-1:0] spi_rx_data,
  output logic          spi_rx_valid,
  output logic          spi_sck,
  output logic          spi_csn,
  output logic          spi_mosi,
  input  logic          spi_miso
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_END
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] tx_q, tx_d;
  logic [RX-1:0] rx_sh_q, rx_sh_d;
  logic [RX-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          csn_q, csn_d;
  logic          mosi_q, mosi_d;
  logic          complete_q, complete_d;
  logic          rx_valid_q, rx_valid_d;
  logic          last_bit;

  // The HIGH phase of bit DW-1 closes the frame.
  assign last_bit = (cnt_q == CW'(DW - 1));

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples values from before the edge regardless of statement order.
    if (rst) begin
      // NOTE: the shift registers are reset as well. spi_rx_data must read
      // zero after reset, and a few flops cost nothing to clear.
      state_q    <= S_IDLE;
      tx_q       <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      sck_q      <= 1'b0;
      csn_q      <= 1'b1;
      mosi_q     <= 1'b0;
      complete_q <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      sck_q      <= sck_d;
      csn_q      <= csn_d;
      mosi_q     <= mosi_d;
      complete_q <= complete_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  // Next-state logic. A start request outside IDLE is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (spi_start) state_d = S_LOW;
      S_LOW:  state_d = S_HIGH;
      S_HIGH: state_d = last_bit ? S_END : S_LOW;
      S_END:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the outputs and datapath for the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case. A path that leaves
    // one unassigned would infer a latch.
    tx_d       = tx_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    cnt_d      = cnt_q;
    sck_d      = sck_q;
    csn_d      = csn_q;
    mosi_d     = mosi_q;
    complete_d = 1'b0;
    rx_valid_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        csn_d  = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
        if (spi_start) begin
          tx_d    = spi_tx_data;
          csn_d   = 1'b0;
          mosi_d  = spi_tx_data[DW-1];
          cnt_d   = '0;
          rx_sh_d = '0;
        end
      end
      S_LOW: begin
        sck_d = 1'b1;
      end
      S_HIGH: begin
        sck_d   = 1'b0;
        rx_sh_d = {rx_sh_q[RX-2:0], spi_miso};
        cnt_d   = cnt_q + CW'(1);
        if (!last_bit) begin
          // Rotate so the next lower bit sits just below the MSB. The
          // wrapped bit is never shifted out because the frame ends first.
          tx_d   = {tx_q[DW-2:0], tx_q[DW-1]};
          mosi_d = tx_q[DW-2];
        end
      end
      S_END: begin
        csn_d      = 1'b1;
        mosi_d     = 1'b0;
        complete_d = 1'b1;
        rx_valid_d = 1'b1;
        rx_data_d  = rx_sh_q;
      end
      default: begin
        csn_d  = 1'b1;
        sck_d  = 1'b0;
        mosi_d = 1'b0;
      end
    endcase
  end

  assign spi_complete = complete_q;
  assign spi_rx_data  = rx_data_q;
  assign spi_rx_valid = rx_valid_q;
  assign spi_sck      = sck_q;
  assign spi_csn      = csn_q;
  assign spi_mosi     = mosi_q;

endmodule

// File: tb/tb_host_spi.sv
// Directed bench for host_spi. Every launched frame pushes its expected MOSI
// stream and receive word. A negedge monitor pops and compares on each
// complete pulse.
module tb_host_spi;

  localparam int DW = 24;
  localparam int RX = 18;

  logic          clk;
  logic          rst;
  logic          spi_start;
  logic [DW-1:0] spi_tx_data;
  logic          spi_complete;
  logic [RX-1:0] spi_rx_data;
  logic          spi_rx_valid;
  logic          spi_sck;
  logic          spi_csn;
  logic          spi_mosi;
  logic          spi_miso;

  logic          loopback;
  logic [DW-1:0] dev_word;
  logic          dev_miso;

  typedef struct packed {
    logic [DW-1:0] frame;
    logic [RX-1:0] rx;
  } exp_t;

  exp_t sb_q[$];

  int total = 0;
  int bad = 0;
  int comp_cnt = 0;

  host_spi #(.DW(DW), .RX(RX)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_start   (spi_start),
    .spi_tx_data (spi_tx_data),
    .spi_complete(spi_complete),
    .spi_rx_data (spi_rx_data),
    .spi_rx_valid(spi_rx_valid),
    .spi_sck     (spi_sck),
    .spi_csn     (spi_csn),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign spi_miso = loopback ? spi_mosi : dev_miso;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Device model: presents the next bit of dev_word half a clock after each
  // SCK fall. Bit 0 is presented once chip select drops.
  int   dev_idx = 0;
  logic dev_prev_sck = 1'b0;
  always @(negedge clk) begin
    if (spi_csn) dev_idx = 0;
    else if (dev_prev_sck && !spi_sck) dev_idx++;
    dev_prev_sck = spi_sck;
    dev_miso = (dev_idx < DW) ? dev_word[DW-1-dev_idx] : 1'b0;
  end

  // Monitor: captures MOSI on each SCK rise, counts chip-select-low cycles,
  // and scores the whole frame when complete pulses.
  logic [DW-1:0] mon_mosi = '0;
  int   mon_bits = 0;
  int   mon_csn = 0;
  logic mon_prev_sck = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst) begin
      mon_mosi = '0;
      mon_bits = 0;
      mon_csn = 0;
      mon_prev_sck = 1'b0;
    end else begin
      if (spi_sck && !mon_prev_sck) begin
        mon_mosi = {mon_mosi[DW-2:0], spi_mosi};
        mon_bits++;
      end
      mon_prev_sck = spi_sck;
      if (!spi_csn) mon_csn++;
      if (spi_complete || spi_rx_valid)
        check("rx_valid_with_complete", 64'(spi_rx_valid), 64'(spi_complete));
      if (spi_complete) begin
        comp_cnt++;
        check("scoreboard_empty_at_complete", 64'(sb_q.size() == 0), 64'(0));
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check("mosi_stream", 64'(mon_mosi), 64'(mon_e.frame));
          check("sck_rising_edges", 64'(mon_bits), 64'(DW));
          check("csn_low_cycles", 64'(mon_csn), 64'(2 * DW + 1));
          check("rx_data", 64'(spi_rx_data), 64'(mon_e.rx));
        end
        mon_mosi = '0;
        mon_bits = 0;
        mon_csn = 0;
      end
    end
  end

  // Called at a negedge: start is seen at the next posedge (E0). Returns at
  // the negedge after E0 with start low and tx_data scrambled.
  task automatic launch(input logic [DW-1:0] tx, input logic [RX-1:0] rx_exp);
    spi_start = 1'b1;
    spi_tx_data = tx;
    sb_q.push_back('{frame: tx, rx: rx_exp});
    @(posedge clk);
    @(negedge clk);
    spi_start = 1'b0;
    spi_tx_data = ~tx;
  endtask

  // Bounded wait for the completion count to reach target. Returns at a
  // negedge.
  task automatic wait_complete(input int target, input string tag);
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      if (comp_cnt >= target) break;
    end
    @(negedge clk);
    check(tag, 64'(comp_cnt), 64'(target));
  endtask

  logic [DW-1:0] tx_a, tx_b, tx_c, tx_d, tx_e, tx_i;

  initial begin
    rst = 1'b1;
    spi_start = 1'b0;
    spi_tx_data = '0;
    loopback = 1'b0;
    dev_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_csn", 64'(spi_csn), 64'(1));
    check("reset_sck", 64'(spi_sck), 64'(0));
    check("reset_mosi", 64'(spi_mosi), 64'(0));
    check("reset_complete", 64'(spi_complete), 64'(0));
    check("reset_rx_valid", 64'(spi_rx_valid), 64'(0));
    check("reset_rx_data", 64'(spi_rx_data), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Write frame with the device driving zeros.
    launch(24'h810101, 18'h0);
    wait_complete(1, "write_complete_count");

    // Loopback: MISO follows MOSI, so the low RX bits of tx come back.
    loopback = 1'b1;
    launch(24'h810102, 18'h10102);
    wait_complete(2, "loopback_complete_count");
    loopback = 1'b0;

    // Read frame: the device returns 18'h0ABCD over the last 18 bits.
    dev_word = {6'b0, 18'h0ABCD};
    launch({2'b01, 3'd5, 1'b0, 18'b0}, 18'h0ABCD);
    wait_complete(3, "read_complete_count");
    repeat (5) @(negedge clk);
    check("rx_data_hold_idle", 64'(spi_rx_data), 64'(18'h0ABCD));
    dev_word = '0;

    // Starts at E3 and E(2DW+1) are ignored. A start at E(2DW+2) launches C.
    tx_a = {2'b10, 3'd1, 1'b0, 18'h15555};
    tx_b = {2'b01, 3'd6, 1'b0, 18'h3C3C3};
    tx_c = {2'b10, 3'd3, 1'b0, 18'h2A5A5};
    launch(tx_a, 18'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    spi_start = 1'b1;
    spi_tx_data = tx_b;
    @(posedge clk);
    @(negedge clk);
    spi_start = 1'b0;
    repeat (2 * DW + 1 - 3 - 1) @(posedge clk);
    @(negedge clk);
    spi_start = 1'b1;
    spi_tx_data = tx_b;
    @(posedge clk);
    @(negedge clk);
    spi_start = 1'b0;
    loopback = 1'b1;
    launch(tx_c, tx_c[RX-1:0]);
    check("one_complete_for_frame_a", 64'(comp_cnt), 64'(4));
    wait_complete(5, "frame_c_complete_count");
    loopback = 1'b0;

    // Reset during bit 10 aborts the frame without any pulse.
    tx_d = {2'b10, 3'd2, 1'b0, 18'h1FFFF};
    launch(tx_d, 18'h0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_csn", 64'(spi_csn), 64'(1));
    check("abort_sck", 64'(spi_sck), 64'(0));
    check("abort_complete", 64'(spi_complete), 64'(0));
    check("abort_rx_valid", 64'(spi_rx_valid), 64'(0));
    check("abort_rx_data", 64'(spi_rx_data), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    repeat (60) @(negedge clk);
    check("abort_no_complete", 64'(comp_cnt), 64'(5));
    loopback = 1'b1;
    tx_e = {2'b01, 3'd7, 1'b0, 18'h0F0F1};
    launch(tx_e, tx_e[RX-1:0]);
    wait_complete(6, "after_abort_complete_count");
    loopback = 1'b0;

    // Back-to-back writes: each start lands on the first IDLE cycle.
    for (int i = 0; i < 8; i++) begin
      tx_i = {2'b10, 3'(i), 1'b0, 18'h10101 + 18'(i)};
      launch(tx_i, 18'h0);
      repeat (2 * DW + 1) @(posedge clk);
      @(negedge clk);
    end
    wait_complete(14, "back_to_back_complete_count");
    repeat (10) @(negedge clk);
    check("final_complete_count", 64'(comp_cnt), 64'(14));
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
